// File: rtl/brisc_pkg.sv
// Shared types for the brisc memory subsystem: cache/memory request and
// response records plus the arbiter's owner and state encodings.
package brisc_pkg;

    typedef struct packed {
        logic         valid;
        logic         rw;
        logic [31:0]  addr;
        logic [127:0] data;
    } mem_req_t;

    typedef struct packed {
        logic         ready;
        logic [31:0]  addr;
        logic [127:0] data;
    } mem_resp_t;

    typedef enum logic {
        ICACHE_REQ = 1'b0,
        DCACHE_REQ = 1'b1
    } mem_owner_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_DONE
    } mem_arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the main-memory port between icache and dcache.
// state | meaning
// IDLE  | no transaction; grant a valid requester (round-robin on a tie)
// ISSUE | latched request driven downstream until memory returns ready
// DONE  | one-cycle gap so memory sees valid low and requester drops valid
module mem_arbiter
    import brisc_pkg::*;
#(
    parameter int   NUM_REQ          = 2,
    parameter logic RESET_LAST_OWNER = 1'b0
) (
    input  logic      clk,
    input  logic      reset,
    input  mem_req_t  icache_req_i,
    output mem_resp_t icache_resp_o,
    input  mem_req_t  dcache_req_i,
    output mem_resp_t dcache_resp_o,
    output mem_req_t  mem_req_o,
    input  mem_resp_t mem_resp_i,
    output logic      busy_o,
    output logic      owner_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]         state_q;
    mem_owner_e         owner_q;
    mem_owner_e         last_owner_q;
    mem_req_t           req_q;
    logic [NUM_REQ-1:0] req_valid;
    logic               pick;

    assign req_valid = {dcache_req_i.valid, icache_req_i.valid};

    // On a tie the requester that did not finish last wins.
    always_comb begin
        pick = 1'b0;
        if (&req_valid) begin
            pick = ~last_owner_q;
        end else if (req_valid[1]) begin
            pick = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= mem_owner_e'(RESET_LAST_OWNER);
            last_owner_q <= mem_owner_e'(RESET_LAST_OWNER);
            req_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req_valid) begin
                        req_q   <= pick ? dcache_req_i : icache_req_i;
                        owner_q <= mem_owner_e'(pick);
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_resp_i.ready) begin
                        last_owner_q <= owner_q;
                        state_q      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Responses outside ISSUE are stray and never reach a cache.
    always_comb begin
        mem_req_o     = '0;
        icache_resp_o = '0;
        dcache_resp_o = '0;
        if (state_q == ST_ISSUE) begin
            mem_req_o       = req_q;
            mem_req_o.valid = 1'b1;
            if (mem_resp_i.ready) begin
                if (owner_q == DCACHE_REQ) begin
                    dcache_resp_o = mem_resp_i;
                end else begin
                    icache_resp_o = mem_resp_i;
                end
            end
        end
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign owner_o = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// random traffic compared every cycle against a transaction-level model.
module tb_mem_arbiter;
    import brisc_pkg::*;

    logic      clk = 1'b0;
    logic      reset;
    mem_req_t  icache_req, dcache_req, mem_req;
    mem_resp_t icache_resp, dcache_resp, mem_resp;
    logic      busy, owner;

    always #5 clk = ~clk;

    mem_arbiter #(.NUM_REQ(2), .RESET_LAST_OWNER(1'b0)) dut (
        .clk           (clk),
        .reset         (reset),
        .icache_req_i  (icache_req),
        .icache_resp_o (icache_resp),
        .dcache_req_i  (dcache_req),
        .dcache_resp_o (dcache_resp),
        .mem_req_o     (mem_req),
        .mem_resp_i    (mem_resp),
        .busy_o        (busy),
        .owner_o       (owner)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: a transaction in flight, a one-cycle cooldown after it.
    bit       m_xfer  = 1'b0;
    bit       m_cool  = 1'b0;
    logic     m_owner = 1'b0;
    logic     m_last  = 1'b0;
    mem_req_t m_req   = '0;
    bit       seen_i  = 1'b0;
    bit       seen_d  = 1'b0;

    always @(negedge clk) begin
        mem_req_t  e_req;
        mem_resp_t e_i, e_d;
        logic      who;
        e_req = '0;
        e_i   = '0;
        e_d   = '0;
        if (m_xfer) begin
            e_req       = m_req;
            e_req.valid = 1'b1;
            if (mem_resp.ready) begin
                if (m_owner) e_d = mem_resp;
                else         e_i = mem_resp;
            end
        end
        seen_i = e_i.ready;
        seen_d = e_d.ready;
        check("model_mem_req", mem_req, e_req);
        check("model_icache_resp", icache_resp, e_i);
        check("model_dcache_resp", dcache_resp, e_d);
        check("model_busy", busy, m_xfer || m_cool);
        check("model_owner", owner, m_owner);

        if (reset) begin
            m_xfer  = 1'b0;
            m_cool  = 1'b0;
            m_owner = 1'b0;
            m_last  = 1'b0;
        end else if (m_xfer) begin
            if (mem_resp.ready) begin
                m_xfer = 1'b0;
                m_cool = 1'b1;
                m_last = m_owner;
            end
        end else if (m_cool) begin
            m_cool = 1'b0;
        end else if (icache_req.valid || dcache_req.valid) begin
            who     = (icache_req.valid && dcache_req.valid) ? !m_last : dcache_req.valid;
            m_req   = who ? dcache_req : icache_req;
            m_owner = who;
            m_xfer  = 1'b1;
        end
    end

    function automatic mem_req_t next_req(input mem_req_t cur, input bit got);
        mem_req_t r;
        r = cur;
        if (cur.valid && got) begin
            r.valid = 1'b0;
        end else if (!cur.valid) begin
            if ($urandom_range(0, 2) == 0) begin
                r.valid = 1'b1;
                r.rw    = 1'($urandom_range(0, 1));
                r.addr  = $urandom() & 32'hFFFF_FFF0;
                r.data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
        end else if ($urandom_range(0, 7) == 0) begin
            r.addr = $urandom();
        end
        return r;
    endfunction

    logic seq [4];

    initial begin
        int mem_cnt;
        int t;
        reset      = 1'b1;
        icache_req = '0;
        dcache_req = '0;
        mem_resp   = '0;
        icache_req.valid = 1'b1;
        icache_req.addr  = 32'h0000_1000;
        dcache_req.valid = 1'b1;
        dcache_req.rw    = 1'b1;
        dcache_req.addr  = 32'h0000_4000;
        dcache_req.data  = {4{32'hA5A5_A5A5}};

        // reset with both valids high
        tick();
        tick();
        check("rst_mem_valid", mem_req.valid, 1'b0);
        check("rst_icache_ready", icache_resp.ready, 1'b0);
        check("rst_dcache_ready", dcache_resp.ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_owner", owner, 1'b0);
        reset = 1'b0;

        // simultaneous: dcache write first
        tick();
        check("sim_d_valid", mem_req.valid, 1'b1);
        check("sim_d_addr", mem_req.addr, 32'h0000_4000);
        check("sim_d_rw", mem_req.rw, 1'b1);
        check("sim_d_data", mem_req.data, {4{32'hA5A5_A5A5}});
        check("sim_d_owner", owner, 1'b1);
        dcache_req.addr = 32'hFFFF_0000;
        tick();
        check("stable_addr", mem_req.addr, 32'h0000_4000);
        mem_resp.ready = 1'b1;
        mem_resp.addr  = 32'h0000_4000;
        mem_resp.data  = {4{32'h1357_9BDF}};
        #1;
        check("sim_d_resp_ready", dcache_resp.ready, 1'b1);
        check("sim_d_resp_data", dcache_resp.data, {4{32'h1357_9BDF}});
        check("sim_d_other_ready", icache_resp.ready, 1'b0);
        tick();
        mem_resp         = '0;
        dcache_req.valid = 1'b0;
        check("gap1_valid", mem_req.valid, 1'b0);
        tick();
        check("gap2_valid", mem_req.valid, 1'b0);
        tick();
        check("i_valid", mem_req.valid, 1'b1);
        check("i_addr", mem_req.addr, 32'h0000_1000);
        check("i_rw", mem_req.rw, 1'b0);
        check("i_owner", owner, 1'b0);
        mem_resp.ready = 1'b1;
        mem_resp.addr  = 32'h0000_1000;
        mem_resp.data  = 128'hDEADBEEF_00112233_44556677_89AB0123;
        #1;
        check("i_resp_ready", icache_resp.ready, 1'b1);
        check("i_resp_data", icache_resp.data, 128'hDEADBEEF_00112233_44556677_89AB0123);
        check("i_other_ready", dcache_resp.ready, 1'b0);
        tick();
        mem_resp         = '0;
        icache_req.valid = 1'b0;
        check("i_after_valid", mem_req.valid, 1'b0);

        // stray ready while idle
        tick();
        mem_resp.ready = 1'b1;
        #1;
        check("stray_icache_ready", icache_resp.ready, 1'b0);
        check("stray_dcache_ready", dcache_resp.ready, 1'b0);
        tick();
        mem_resp = '0;

        // reset two cycles into ISSUE
        icache_req.valid = 1'b1;
        icache_req.addr  = 32'h0000_2000;
        tick();
        check("rmid_issue_valid", mem_req.valid, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        check("rmid_valid", mem_req.valid, 1'b0);
        check("rmid_busy", busy, 1'b0);
        reset            = 1'b0;
        icache_req.valid = 1'b0;
        mem_resp.ready   = 1'b1;
        #1;
        check("rmid_late_ready", icache_resp.ready, 1'b0);
        tick();
        mem_resp = '0;

        // fairness with both continuously valid
        icache_req.valid = 1'b1;
        icache_req.addr  = 32'h0000_1000;
        dcache_req.valid = 1'b1;
        dcache_req.addr  = 32'h0000_4000;
        for (int k = 0; k < 4; k++) begin
            t = 0;
            while (!mem_req.valid && t < 10) begin
                tick();
                t++;
            end
            check("fair_wait", (t < 10), 1'b1);
            seq[k]         = owner;
            mem_resp.ready = 1'b1;
            mem_resp.data  = {4{32'(k)}};
            tick();
            mem_resp = '0;
        end
        for (int k = 0; k < 4; k++) begin
            check("fair_owner", seq[k], (k % 2 == 0) ? 1'b1 : 1'b0);
        end
        icache_req.valid = 1'b0;
        dcache_req.valid = 1'b0;
        tick();
        tick();
        tick();

        // random traffic checked by the model
        mem_cnt = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            reset      = ($urandom_range(0, 299) == 0);
            icache_req = next_req(icache_req, seen_i);
            dcache_req = next_req(dcache_req, seen_d);
            if (mem_req.valid && !mem_resp.ready) begin
                if (mem_cnt == 0) begin
                    mem_resp.ready = 1'b1;
                    mem_resp.addr  = mem_req.addr;
                    mem_resp.data  = {$urandom(), $urandom(), $urandom(), $urandom()};
                end else begin
                    mem_cnt--;
                end
            end else begin
                mem_resp.ready = (!mem_req.valid) && ($urandom_range(0, 7) == 0);
                mem_resp.addr  = $urandom();
                mem_resp.data  = {$urandom(), $urandom(), $urandom(), $urandom()};
                mem_cnt        = $urandom_range(0, 4);
            end
        end

        reset      = 1'b0;
        icache_req = '0;
        dcache_req = '0;
        mem_resp   = '0;
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
